if_fetch_bpu: RTL and testbench

- Fetch-stage producer for the IF/ID pipeline register.
- Owns the PC register and drives the instruction-memory address.
- Contains a direct-mapped BTB with 2-bit saturating counters for branch prediction.
- Presents PC_if, inst_if, bp_if and BTB_target_if to the IF/ID register, honours the shared stall code, and accepts mispredict redirects and branch-resolution updates from EX.

---
 rtl/if_fetch_bpu_pkg.sv | 37 +++
 rtl/if_fetch_bpu_if.sv | 32 +++
 rtl/if_fetch_bpu_btb_dm.sv | 62 ++++++
 rtl/if_fetch_bpu.sv | 67 ++++++
 tb/tb_if_fetch_bpu.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_bpu_pkg.sv
// Shared definitions for the fetch stage: stall encoding, bus widths,
// BTB entry layout and 2-bit saturating counter helpers.
package if_fetch_bpu_pkg;

    localparam int          STALL_WIDTH    = 2;
    localparam logic [1:0]  STALL_NONE     = 2'b00;
    localparam logic [1:0]  STALL_LOAD     = 2'b01;
    localparam logic [1:0]  STALL_BRANCH   = 2'b10;
    localparam int          MEM_ADDR_WIDTH = 32;
    localparam int          REG_DATA_WIDTH = 32;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Tag is held zero-extended to 32 bits so the layout is independent of BTB size.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        ctr_t        ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        ctr_t r;
        if (taken) begin
            r = (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
        end else begin
            r = (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
        end
        return r;
    endfunction

endpackage

// File: rtl/if_fetch_bpu_if.sv
// Fetch-stage bus: EX redirect/update inputs, instruction memory port and
// the values presented to the IF/ID register.
interface if_fetch_bpu_if;
    import if_fetch_bpu_pkg::*;

    logic [STALL_WIDTH-1:0]    stall;
    logic                      redirect;
    logic [MEM_ADDR_WIDTH-1:0] redirect_pc;
    logic                      upd_valid;
    logic [MEM_ADDR_WIDTH-1:0] upd_pc;
    logic                      upd_taken;
    logic [31:0]               upd_target;
    logic [MEM_ADDR_WIDTH-1:0] imem_addr;
    logic [REG_DATA_WIDTH-1:0] imem_rdata;
    logic [MEM_ADDR_WIDTH-1:0] PC_if;
    logic [REG_DATA_WIDTH-1:0] inst_if;
    logic                      bp_if;
    logic [31:0]               BTB_target_if;

    modport master (
        output stall, redirect, redirect_pc, upd_valid, upd_pc, upd_taken,
               upd_target, imem_rdata,
        input  imem_addr, PC_if, inst_if, bp_if, BTB_target_if
    );

    modport slave (
        input  stall, redirect, redirect_pc, upd_valid, upd_pc, upd_taken,
               upd_target, imem_rdata,
        output imem_addr, PC_if, inst_if, bp_if, BTB_target_if
    );

endinterface

// File: rtl/if_fetch_bpu_btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// registered update from branch resolution.
module if_fetch_bpu_btb_dm
    import if_fetch_bpu_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t       entries_r [BTB_ENTRIES];
    logic [IDX_W-1:0] lk_idx_s;
    logic [31:0]      lk_tag_s;
    btb_entry_t       lk_entry_s;
    logic             lk_hit_s;
    logic [IDX_W-1:0] up_idx_s;
    logic [31:0]      up_tag_s;
    btb_entry_t       up_entry_s;
    logic             up_hit_s;

    assign lk_idx_s   = lookup_pc[IDX_W+1:2];
    assign lk_tag_s   = lookup_pc >> (IDX_W + 2);
    assign lk_entry_s = entries_r[lk_idx_s];
    assign lk_hit_s   = lk_entry_s.valid && (lk_entry_s.tag == lk_tag_s);

    assign pred_taken  = lk_hit_s && lk_entry_s.ctr[1];
    assign pred_target = lk_entry_s.target;

    assign up_idx_s   = upd_pc[IDX_W+1:2];
    assign up_tag_s   = upd_pc >> (IDX_W + 2);
    assign up_entry_s = entries_r[up_idx_s];
    assign up_hit_s   = up_entry_s.valid && (up_entry_s.tag == up_tag_s);

    // Entry array: reset to empty/weakly-not-taken, train on hit, allocate on taken miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                entries_r[i] <= '{valid: 1'b0, tag: 32'h0, target: 32'h0, ctr: CTR_WNT};
            end
        end else if (upd_valid) begin
            if (up_hit_s) begin
                entries_r[up_idx_s].ctr <= ctr_update(up_entry_s.ctr, upd_taken);
                if (upd_taken) begin
                    entries_r[up_idx_s].target <= upd_target;
                end
            end else if (upd_taken) begin
                entries_r[up_idx_s] <= '{valid: 1'b1, tag: up_tag_s, target: upd_target, ctr: CTR_WT};
            end
        end
    end

endmodule

// File: rtl/if_fetch_bpu.sv
// Fetch stage: owns the PC, drives instruction memory and predicts the next
// PC through a direct-mapped BTB.
module if_fetch_bpu
    import if_fetch_bpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic           clk,
    input  logic           rst,
    if_fetch_bpu_if.slave  bus
);

    logic [MEM_ADDR_WIDTH-1:0] pc_r;
    logic [MEM_ADDR_WIDTH-1:0] pc_plus4_s;
    logic [MEM_ADDR_WIDTH-1:0] next_pc_s;
    logic                      hold_s;
    logic                      pred_taken_s;
    logic [31:0]               pred_target_s;

    if_fetch_bpu_btb_dm #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc_r),
        .pred_taken  (pred_taken_s),
        .pred_target (pred_target_s),
        .upd_valid   (bus.upd_valid),
        .upd_pc      (bus.upd_pc),
        .upd_taken   (bus.upd_taken),
        .upd_target  (bus.upd_target)
    );

    assign pc_plus4_s = pc_r + 32'd4;
    assign hold_s     = (bus.stall == STALL_LOAD) || (bus.stall == STALL_BRANCH);

    // Next-PC select: redirect beats stall, stall beats prediction.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (bus.redirect) begin
            next_pc_s = bus.redirect_pc;
        end else if (hold_s) begin
            next_pc_s = pc_r;
        end else if (pred_taken_s) begin
            next_pc_s = pred_target_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign bus.imem_addr     = pc_r;
    assign bus.PC_if         = pc_r;
    assign bus.inst_if       = bus.imem_rdata;
    assign bus.bp_if         = pred_taken_s;
    assign bus.BTB_target_if = pred_taken_s ? pred_target_s : pc_plus4_s;

endmodule

// File: tb/tb_if_fetch_bpu.sv
// Bench for if_fetch_bpu: directed scenarios then random traffic, checked
// against an array-based model of PC sequencing and BTB prediction.
module tb_if_fetch_bpu;

    localparam int          NE       = 16;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    if_fetch_bpu_if bus ();

    if_fetch_bpu #(
        .RESET_PC    (RST_PC),
        .BTB_ENTRIES (NE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_known = 1'b0;
    logic [31:0] m_pc;
    bit          m_valid [NE];
    logic [31:0] m_tag   [NE];
    logic [31:0] m_tgt   [NE];
    int          m_ctr   [NE];

    function automatic void model_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'h0;
            m_tgt[i]   = 32'h0;
            m_ctr[i]   = 1;
        end
        m_pc = RST_PC;
    endfunction

    function automatic void predict(input logic [31:0] pc, output logic taken, output logic [31:0] tgt);
        int i;
        i     = int'((pc / 4) % NE);
        taken = m_valid[i] && (m_tag[i] == pc / (4 * NE)) && (m_ctr[i] >= 2);
        tgt   = taken ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        int i;
        i = int'((pc / 4) % NE);
        if (m_valid[i] && m_tag[i] == pc / (4 * NE)) begin
            if (taken) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = pc / (4 * NE);
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic r, input logic [1:0] st, input logic rd, input logic [31:0] rpc,
                        input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                        input string nm);
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] nxt;
        logic [31:0] word;
        @(negedge clk);
        word            = $urandom;
        rst             = r;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.upd_valid   = uv;
        bus.upd_pc      = upc;
        bus.upd_taken   = ut;
        bus.upd_target  = utgt;
        bus.imem_rdata  = word;
        #1;
        if (m_known) begin
            predict(m_pc, pt, ptgt);
            chk({nm, ".pc"},   bus.PC_if,              m_pc);
            chk({nm, ".addr"}, bus.imem_addr,          m_pc);
            chk({nm, ".inst"}, bus.inst_if,            word);
            chk({nm, ".bp"},   32'(bus.bp_if),         32'(pt));
            chk({nm, ".tgt"},  bus.BTB_target_if,      ptgt);
        end
        if (r) begin
            model_reset();
            m_known = 1'b1;
        end else begin
            predict(m_pc, pt, ptgt);
            if (rd)                          nxt = rpc;
            else if (st == 2'b01 || st == 2'b10) nxt = m_pc;
            else if (pt)                     nxt = ptgt;
            else                             nxt = m_pc + 32'd4;
            if (uv) model_update(upc, ut, utgt);
            m_pc = nxt;
        end
    endtask

    initial begin
        bus.stall       = 2'b00;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = 32'h0;
        bus.upd_taken   = 1'b0;
        bus.upd_target  = 32'h0;
        bus.imem_rdata  = 32'h0;

        // Reset, with an update that must be ignored
        step(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0,  "rst0");
        step(1'b1, 2'b00, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h40, "rst1");

        // Sequential fetch and load stall
        step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "seq0");
        chk("reset_pc",  bus.PC_if,         32'h0);
        chk("reset_bp",  32'(bus.bp_if),    32'h0);
        chk("reset_tgt", bus.BTB_target_if, 32'h4);
        step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "seq1");
        step(1'b0, 2'b01, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "ld0");
        step(1'b0, 2'b01, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "ld1");
        step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "ld2");
        chk("ld_hold3", bus.PC_if, 32'h8);
        step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "ld3");
        chk("ld_after", bus.PC_if, 32'hC);

        // Branch stall, then code 2'b11 which must not hold
        step(1'b0, 2'b00, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, "rd8");
        step(1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "br0");
        step(1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "br1");
        step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "br2");
        step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "br3");
        chk("br_after", bus.PC_if, 32'hC);
        step(1'b0, 2'b11, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "s11a");
        step(1'b0, 2'b11, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "s11b");
        chk("s11_nohold", bus.PC_if, 32'h14);

        // Allocate 0x10 -> 0x40 and follow the prediction
        step(1'b0, 2'b00, 1'b1, 32'h8, 1'b1, 32'h10, 1'b1, 32'h40, "alloc");
        step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0,  "f8");
        step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0,  "fC");
        step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0,  "f10");
        chk("alloc_bp",  32'(bus.bp_if),    32'h1);
        chk("alloc_tgt", bus.BTB_target_if, 32'h40);
        step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0,  "f40");
        chk("follow_pc", bus.PC_if, 32'h40);

        // Counter training: 10 -> 11 -> 10 -> 01 -> 00, then one taken stays below threshold
        step(1'b0, 2'b00, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 32'h40, "tr_t");
        step(1'b0, 2'b00, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'h0,  "tr_n1");
        step(1'b0, 2'b00, 1'b1, 32'h10, 1'b0, 32'h0,  1'b0, 32'h0,  "tr_r1");
        step(1'b0, 2'b00, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'h0,  "tr_n2");
        chk("ctr10_bp", 32'(bus.bp_if), 32'h1);
        step(1'b0, 2'b00, 1'b1, 32'h10, 1'b0, 32'h0,  1'b0, 32'h0,  "tr_r2");
        step(1'b0, 2'b00, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'h0,  "tr_n3");
        chk("ctr01_bp", 32'(bus.bp_if), 32'h0);
        step(1'b0, 2'b00, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'h40, "tr_t2");
        chk("ctr01_next", bus.PC_if, 32'h14);
        step(1'b0, 2'b00, 1'b1, 32'h10, 1'b0, 32'h0,  1'b0, 32'h0,  "tr_r3");
        step(1'b0, 2'b00, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,  "tr_sat");
        chk("ctr_sat_bp", 32'(bus.bp_if), 32'h0);

        // Aliasing on the same index with a different tag
        step(1'b0, 2'b00, 1'b1, 32'h50, 1'b0, 32'h0,  1'b0, 32'h0,  "al_r");
        step(1'b0, 2'b00, 1'b1, 32'h10, 1'b1, 32'h50, 1'b1, 32'h80, "al_50");
        chk("alias_miss", 32'(bus.bp_if), 32'h0);
        step(1'b0, 2'b00, 1'b1, 32'h50, 1'b0, 32'h0,  1'b0, 32'h0,  "al_10");
        chk("replaced_miss", 32'(bus.bp_if), 32'h0);
        step(1'b0, 2'b00, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,  "al_50b");
        chk("alias_hit", 32'(bus.bp_if), 32'h1);
        chk("alias_tgt", bus.BTB_target_if, 32'h80);

        // Redirect overrides branch stall
        step(1'b0, 2'b10, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, "rd_st");
        step(1'b0, 2'b00, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0, "rd_200");
        chk("redirect_pc", bus.PC_if, 32'h200);

        // Reset mid-run with update and redirect pending
        step(1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 32'h10, 1'b1, 32'h40, "pre_a");
        step(1'b0, 2'b00, 1'b1, 32'h10,  1'b0, 32'h0,  1'b0, 32'h0,  "pre_r");
        step(1'b1, 2'b00, 1'b1, 32'h300, 1'b1, 32'h50, 1'b1, 32'h80, "rst_mid");
        chk("pre_rst_bp", 32'(bus.bp_if), 32'h1);
        step(1'b0, 2'b00, 1'b1, 32'h10,  1'b0, 32'h0,  1'b0, 32'h0,  "post0");
        chk("post_rst_pc", bus.PC_if, RST_PC);
        step(1'b0, 2'b00, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,  "post10");
        chk("post_rst_bp", 32'(bus.bp_if), 32'h0);

        // Random traffic over a small address window to force hits and aliases
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 63) == 0),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0),
                 32'($urandom_range(0, 255)) << 2,
                 ($urandom_range(0, 1) == 1),
                 32'($urandom_range(0, 255)) << 2,
                 ($urandom_range(0, 1) == 1),
                 32'($urandom_range(0, 255)) << 2,
                 "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
